// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, software interrupt bit and
// a prescaled tick, served over the core's req/ready/rvalid data bus.
module mtimer #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int PW = 16
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            timer_req,
    input  logic            timer_write,
    input  logic [DW/8-1:0] timer_wstrb,
    input  logic [AW-1:0]   timer_addr,
    input  logic [DW-1:0]   timer_wdata,
    output logic            timer_ready,
    output logic            timer_rvalid,
    output logic [DW-1:0]   timer_rdata,
    output logic            timer_interrupt,
    output logic            software_interrupt
);

    // Bus handshake: a request is taken in any cycle where timer_req and
    // timer_ready are both high; a taken read answers with timer_rvalid for
    // exactly one cycle on the following cycle, and timer_rdata is 0 otherwise.

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_MSIP     = 3'd4;
    localparam logic [2:0] A_PRESCALE = 3'd5;
    localparam logic [2:0] A_CTRL     = 3'd6;

    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic          enable;
    logic [PW-1:0] prescale;
    logic [PW-1:0] pre_cnt;
    logic [31:0]   hi_shadow;

    logic          accept;
    logic          rd_acc;
    logic          wr_eff;
    logic [2:0]    idx;
    logic          tick;
    logic          mtime_wr;
    logic [31:0]   pre_ext;
    logic [31:0]   rd_val;
    logic [31:0]   cur_val;
    logic [31:0]   wr_val;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{timer_addr[AW-1:5], timer_addr[1:0]};

    assign idx      = timer_addr[4:2];
    assign accept   = timer_req & timer_ready;
    assign rd_acc   = accept & ~timer_write;
    assign wr_eff   = accept & timer_write & (|timer_wstrb);
    assign tick     = enable && (pre_cnt == prescale);
    assign mtime_wr = wr_eff && ((idx == A_MTIME_LO) || (idx == A_MTIME_HI));

    always_comb begin
        pre_ext = '0;
        pre_ext[PW-1:0] = prescale;
    end

    // Current contents of the addressed register, used both as read data and
    // as the base for byte-masked writes.
    always_comb begin
        cur_val = '0;
        case (idx)
            A_MTIME_LO: cur_val = mtime[31:0];
            A_MTIME_HI: cur_val = mtime[63:32];
            A_CMP_LO:   cur_val = mtimecmp[31:0];
            A_CMP_HI:   cur_val = mtimecmp[63:32];
            A_MSIP:     cur_val[0] = msip;
            A_PRESCALE: cur_val = pre_ext;
            A_CTRL:     cur_val[0] = enable;
            default:    cur_val = '0;
        endcase
    end

    // MTIME_HI reads come from the shadow so a LO-then-HI pair is coherent.
    always_comb begin
        rd_val = cur_val;
        if (idx == A_MTIME_HI) rd_val = hi_shadow;
    end

    always_comb begin
        wr_val = cur_val;
        for (int b = 0; b < 4; b++) begin
            if (timer_wstrb[b]) wr_val[8*b +: 8] = timer_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            timer_ready     <= 1'b0;
            timer_rvalid    <= 1'b0;
            timer_rdata     <= '0;
            timer_interrupt <= 1'b0;
            mtime           <= '0;
            mtimecmp        <= '1;
            msip            <= 1'b0;
            enable          <= 1'b0;
            prescale        <= '0;
            pre_cnt         <= '0;
            hi_shadow       <= '0;
        end else begin
            timer_ready     <= 1'b1;
            timer_rvalid    <= rd_acc;
            timer_rdata     <= rd_acc ? rd_val : '0;
            timer_interrupt <= (mtime >= mtimecmp);

            if (rd_acc && (idx == A_MTIME_LO)) hi_shadow <= mtime[63:32];

            if (enable) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;

            // A bus write to either half beats the tick for the whole register.
            if (mtime_wr) begin
                if (idx == A_MTIME_LO) mtime[31:0]  <= wr_val;
                else                   mtime[63:32] <= wr_val;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_eff) begin
                case (idx)
                    A_CMP_LO:   mtimecmp[31:0]  <= wr_val;
                    A_CMP_HI:   mtimecmp[63:32] <= wr_val;
                    A_MSIP:     msip            <= wr_val[0];
                    A_PRESCALE: begin
                        prescale <= wr_val[PW-1:0];
                        pre_cnt  <= '0;
                    end
                    A_CTRL:     enable          <= wr_val[0];
                    default:    ;
                endcase
            end
        end
    end

    assign software_interrupt = msip;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: directed scenarios plus random bus traffic, compared every
// cycle against a behavioural model of the register map and prescaled time base.
module tb_mtimer;

    logic        clk;
    logic        rst_b;
    logic        timer_req;
    logic        timer_write;
    logic [3:0]  timer_wstrb;
    logic [15:0] timer_addr;
    logic [31:0] timer_wdata;
    logic        timer_ready;
    logic        timer_rvalid;
    logic [31:0] timer_rdata;
    logic        timer_interrupt;
    logic        software_interrupt;

    int n_vec = 0;
    int n_err = 0;

    mtimer #(.AW(16), .DW(32), .PW(16)) dut (
        .clk                (clk),
        .rst_b              (rst_b),
        .timer_req          (timer_req),
        .timer_write        (timer_write),
        .timer_wstrb        (timer_wstrb),
        .timer_addr         (timer_addr),
        .timer_wdata        (timer_wdata),
        .timer_ready        (timer_ready),
        .timer_rvalid       (timer_rvalid),
        .timer_rdata        (timer_rdata),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: architectural registers plus a count of enabled
    // cycles since the prescaler was last restarted.
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_shadow, m_rdata;
    logic        m_msip, m_en, m_ready, m_tint, m_rvalid;
    int          m_pre;
    longint      m_encnt;

    logic [31:0] exp_rst [8];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0: return m_mtime[31:0];
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {31'b0, m_msip};
            3'd5: return 32'(m_pre);
            3'd6: return {31'b0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime = '0; m_cmp = '1; m_shadow = '0; m_rdata = '0;
        m_msip = 0; m_en = 0; m_ready = 0; m_tint = 0; m_rvalid = 0;
        m_pre = 0; m_encnt = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".ready"},  {63'b0, timer_ready},        {63'b0, m_ready});
        chk({tag, ".rvalid"}, {63'b0, timer_rvalid},       {63'b0, m_rvalid});
        chk({tag, ".rdata"},  {32'b0, timer_rdata},        {32'b0, m_rdata});
        chk({tag, ".tint"},   {63'b0, timer_interrupt},    {63'b0, m_tint});
        chk({tag, ".swi"},    {63'b0, software_interrupt}, {63'b0, m_msip});
    endtask

    // Called at a falling edge; drives one bus cycle, advances the model across
    // the rising edge, checks, and returns at the next falling edge.
    task automatic step(input string tag, input logic req, input logic wr, input logic [2:0] idx,
                        input logic [31:0] wd, input logic [3:0] strb);
        logic        acc, tk;
        logic [63:0] n_mtime, n_cmp;
        logic [31:0] n_shadow, n_rdata;
        logic        n_msip, n_en, n_rvalid, n_tint;
        int          n_pre;
        longint      n_encnt;
        timer_req   = req;
        timer_write = wr;
        timer_wstrb = strb;
        timer_wdata = wd;
        timer_addr  = {11'($urandom), idx, 2'($urandom)};

        acc      = req && m_ready;
        tk       = m_en && ((m_encnt % longint'(m_pre + 1)) == longint'(m_pre));
        n_mtime  = tk ? m_mtime + 64'd1 : m_mtime;
        n_encnt  = m_en ? m_encnt + 1 : m_encnt;
        n_cmp    = m_cmp; n_msip = m_msip; n_en = m_en; n_pre = m_pre;
        n_rvalid = acc && !wr;
        n_rdata  = n_rvalid ? model_read(idx) : 32'h0;
        n_shadow = (n_rvalid && idx == 3'd0) ? m_mtime[63:32] : m_shadow;
        n_tint   = (m_mtime >= m_cmp);
        if (acc && wr && strb != 4'b0) begin
            case (idx)
                3'd0: n_mtime = {m_mtime[63:32], merge(m_mtime[31:0], wd, strb)};
                3'd1: n_mtime = {merge(m_mtime[63:32], wd, strb), m_mtime[31:0]};
                3'd2: n_cmp   = {m_cmp[63:32], merge(m_cmp[31:0], wd, strb)};
                3'd3: n_cmp   = {merge(m_cmp[63:32], wd, strb), m_cmp[31:0]};
                3'd4: n_msip  = strb[0] ? wd[0] : m_msip;
                3'd5: begin
                    n_pre   = int'(merge(32'(m_pre), wd, strb) & 32'h0000_FFFF);
                    n_encnt = 0;
                end
                3'd6: n_en    = strb[0] ? wd[0] : m_en;
                default: ;
            endcase
        end

        @(posedge clk);
        #1;
        m_mtime = n_mtime; m_cmp = n_cmp; m_shadow = n_shadow; m_rdata = n_rdata;
        m_msip = n_msip; m_en = n_en; m_pre = n_pre; m_encnt = n_encnt;
        m_rvalid = n_rvalid; m_tint = n_tint; m_ready = 1'b1;
        chk_outputs(tag);
        @(negedge clk);
    endtask

    task automatic wr(input string tag, input logic [2:0] idx, input logic [31:0] wd);
        step(tag, 1, 1, idx, wd, 4'hF);
    endtask

    task automatic rd(input string tag, input logic [2:0] idx);
        step(tag, 1, 0, idx, 32'h0, 4'h0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 3'd0, 32'h0, 4'h0);
    endtask

    initial begin
        exp_rst = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        timer_req = 0; timer_write = 0; timer_wstrb = 0; timer_addr = 0; timer_wdata = 0;
        rst_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("in_reset");

        // Release; ready must stay low until the first edge, and a request
        // offered before that edge must not be taken.
        @(negedge clk);
        rst_b = 1;
        chk("ready_pre_edge", {63'b0, timer_ready}, 64'd0);
        rd("req_before_ready", 3'd2);
        for (int i = 0; i < 8; i++) begin
            rd("rst_read", 3'(i));
            chk("rst_value", {32'b0, timer_rdata}, {32'b0, exp_rst[i]});
        end

        // Prescale 3: one tick every 4 enabled cycles.
        wr("ps_pre", 3'd5, 32'd3);
        wr("ps_en", 3'd6, 32'd1);
        idle("ps_run", 40);
        rd("ps_rd_lo", 3'd0);

        // Carry from LO into HI; HI read must return the shadow from the LO read.
        wr("cy_dis", 3'd6, 32'd0);
        wr("cy_hi", 3'd1, 32'd0);
        wr("cy_lo", 3'd0, 32'hFFFF_FFFE);
        wr("cy_pre", 3'd5, 32'd0);
        wr("cy_en", 3'd6, 32'd1);
        idle("cy_run", 3);
        rd("cy_rd_lo", 3'd0);
        chk("carry_lo", {32'b0, timer_rdata}, 64'd1);
        idle("cy_run2", 2);
        rd("cy_rd_hi", 3'd1);
        chk("carry_hi_shadow", {32'b0, timer_rdata}, 64'd1);

        // Timer interrupt around mtime == mtimecmp, then cleared by raising cmp.
        wr("ti_dis", 3'd6, 32'd0);
        wr("ti_hi", 3'd1, 32'd0);
        wr("ti_lo", 3'd0, 32'h1C);
        wr("ti_cmp_hi", 3'd3, 32'd0);
        wr("ti_cmp_lo", 3'd2, 32'h20);
        wr("ti_en", 3'd6, 32'd1);
        idle("ti_run", 8);
        chk("tint_level", {63'b0, timer_interrupt}, 64'd1);
        wr("ti_raise", 3'd2, 32'hFFFF_FFFF);
        idle("ti_clear", 2);
        chk("tint_cleared", {63'b0, timer_interrupt}, 64'd0);

        // Software interrupt: byte-masked write, read-back, and a wstrb=0 no-op.
        step("msip_set", 1, 1, 3'd4, 32'hFFFF_FFFF, 4'b0001);
        chk("swi_next_cycle", {63'b0, software_interrupt}, 64'd1);
        rd("msip_rd", 3'd4);
        chk("msip_readback", {32'b0, timer_rdata}, 64'd1);
        step("msip_nostrb", 1, 1, 3'd4, 32'h0, 4'b0000);
        chk("swi_hold", {63'b0, software_interrupt}, 64'd1);
        rd("rsvd_rd", 3'd7);

        // Random traffic over the whole map.
        for (int i = 0; i < 400; i++) begin
            logic        r_req, r_wr;
            logic [2:0]  r_idx;
            logic [31:0] r_wd;
            logic [3:0]  r_strb;
            r_req  = ($urandom_range(0, 9) < 7);
            r_wr   = 1'($urandom_range(0, 1));
            r_idx  = 3'($urandom_range(0, 7));
            r_strb = 4'($urandom_range(0, 15));
            r_wd   = $urandom;
            if (r_idx == 3'd5) r_wd = $urandom_range(0, 3);
            if (r_idx == 3'd6) r_wd = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0;
            step("rand", r_req, r_wr, r_idx, r_wd, r_strb);
        end

        // Reset in the rvalid cycle of an accepted read.
        wr("mr_swi", 3'd4, 32'd1);
        rd("mr_read", 3'd2);
        rst_b = 0;
        #1;
        model_reset();
        chk_outputs("mid_reset");
        @(negedge clk);
        rst_b = 1;
        for (int i = 0; i < 8; i++) begin
            rd("post_rst_read", 3'(i));
            if (i > 0) chk("post_rst_value", {32'b0, timer_rdata}, {32'b0, exp_rst[i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped machine timer, responder side of the core's data bus request/ready/rvalid protocol.
- Provides a 64-bit free-running `mtime`, a 64-bit `mtimecmp`, a software-interrupt bit and a prescaler.
- Drives `timer_interrupt` and `software_interrupt` into the core in place of today's tied-off constants.
- Sits behind the SoC address decoder as one more target next to RAM and GPIO.

Parameters:
- AW, 16, width of the byte address seen by the block (only addr[4:2] decoded, rest ignored)
- DW, 32, data bus width; register map defined for 32 only
- PW, 16, prescaler width in bits

Ports:
- clk  input  1  clock
- rst_b  input  1  asynchronous active-low reset
- timer_req  input  1  request valid
- timer_write  input  1  1 = write, 0 = read
- timer_wstrb  input  DW/8  byte write enables
- timer_addr  input  AW  byte address
- timer_wdata  input  DW  write data
- timer_ready  output  1  responder can accept request this cycle
- timer_rvalid  output  1  read data valid
- timer_rdata  output  DW  read data
- timer_interrupt  output  1  mtime >= mtimecmp
- software_interrupt  output  1  MSIP bit 0

Behaviour:
- Reset: one clock `clk`; reset `rst_b` is asynchronous and active-low.
- Reset values:
  - ready 0, rvalid 0, rdata 0
  - mtime 0, mtimecmp 64'hFFFF_FFFF_FFFF_FFFF
  - msip 0, prescale 0, prescale counter 0, enable 0, hi-shadow 0
  - timer_interrupt 0, software_interrupt 0
- ready is a register: 1 from the first clock edge after reset release and then constant 1.
- Request acceptance:
  - A request is accepted when req & ready.
  - One request per cycle; no back-pressure after reset.
- Read response:
  - rvalid=1 exactly one cycle after an accepted read, for one cycle.
  - rdata carries register contents as they were in the accept cycle, before any same-cycle increment.
  - rdata=0 whenever rvalid=0.
  - Writes never produce rvalid.
- Register map (addr[4:2]):
  - 0 MTIME_LO: read snapshots mtime[63:32] into the hi-shadow.
  - 1 MTIME_HI: read returns the hi-shadow, not live mtime; write updates live mtime[63:32].
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 MSIP: bit0 only; other bits read 0.
  - 5 PRESCALE: bits PW-1:0; rest read 0.
  - 6 CTRL: bit0 = enable.
  - 7 reserved: reads 0, writes ignored.
- Writes are byte-granular per wstrb; wstrb=0 is a no-op that is still accepted.
- Prescaler and tick:
  - When enable=1, the counter increments each cycle.
  - When counter == PRESCALE, a tick fires and the counter returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - enable=0 holds both the counter and mtime.
  - A write to PRESCALE resets the counter to 0.
- mtime increment:
  - On a tick, mtime += 1 as a full 64-bit add, with carry from lo into hi.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A bus write to either mtime half in a tick cycle wins: both halves keep write/hold values and there is no increment that cycle.
- Interrupts:
  - timer_interrupt is registered: next = (mtime >= mtimecmp), unsigned 64-bit compare using current register values, so it has 1-cycle latency.
  - The interrupt is level; it clears only when mtimecmp is raised or mtime is written lower.
  - software_interrupt = msip bit0, registered; updates the cycle after the write.
- Reset mid-operation: asserting rst_b low clears all state asynchronously, including a pending rvalid.

Test Plan:
- Reset then read each address 0..7 → rvalid one cycle after accept; values 0,0,FFFFFFFF,FFFFFFFF,0,0,0,0; ready=1 from the first post-reset edge.
- Write CTRL=1, PRESCALE=3; wait 40 cycles → MTIME_LO read shows 10 (±1 per documented accept timing); the counter advances only every 4th cycle.
- Write MTIME_HI=0, MTIME_LO=FFFFFFFE, enable with PRESCALE=0; after 3 ticks read LO then HI → LO=1, HI=1 (shadow captured at LO read, not changed by later carries).
- Write mtimecmp=0x20 (HI=0), enable, PRESCALE=0 → timer_interrupt rises exactly 1 cycle after mtime reaches 0x20; writing MTIMECMP_LO=FFFFFFFF drops it the cycle after the write.
- Write MSIP=0xFFFFFFFF with wstrb=4'b0001 → software_interrupt=1 next cycle; MSIP read returns 1; write with wstrb=0 leaves it unchanged.
- Assert rst_b low in the cycle after an accepted read → rvalid and rdata forced 0 immediately; after release all registers are back at reset values.
